// File: rtl/dma_reg_loader.sv
// dma_reg_loader: register-bus initiator for the dma block's 4-bit address /
// 8-bit data register port. A start pulse captures a full blit descriptor.
// The block then writes registers 0x0..0xA in ascending order and honours reg_wait.
// CTRL (0xA) is always written last because that write launches the transfer.
// When SKIP_UNCHANGED is set, data registers whose byte already matches the last
// committed value are left out, and leaving them out costs no cycles.
module dma_reg_loader #(
  parameter int SKIP_UNCHANGED = 1,
  parameter int WAIT_TIMEOUT   = 255
) (
  input  logic        reg_clk,
  input  logic        reg_rst_n,
  input  logic        start,
  input  logic [16:0] src_off,
  input  logic [16:0] dst_off,
  input  logic [7:0]  width,
  input  logic [8:0]  height,
  input  logic [7:0]  fill,
  input  logic [7:0]  ctrl,
  output logic [3:0]  reg_addr,
  output logic [7:0]  reg_data,
  output logic        reg_cs,
  output logic        reg_we,
  input  logic        reg_wait,
  output logic        busy,
  output logic        done,
  output logic        error
);

  // The counter only has to reach WAIT_TIMEOUT-1. The abort fires on the stall
  // that would take it to WAIT_TIMEOUT.
  localparam int             WCW        = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
  localparam logic [WCW-1:0] WAIT_LAST  = WCW'(WAIT_TIMEOUT - 1);
  localparam bit             TIMEOUT_EN = (WAIT_TIMEOUT != 0);
  localparam bit             SKIP_EN    = (SKIP_UNCHANGED != 0);
  localparam logic [3:0]     CTRL_ADDR  = 4'hA;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_t;

  state_t             state_r, state_s;
  logic [10:0][7:0]   desc_r;          // latched descriptor, one byte per register
  logic [9:0][7:0]    shadow_r;        // last committed values of regs 0x0-0x9
  logic               shadow_valid_r;
  logic [WCW-1:0]     wait_cnt_r, wait_cnt_s;

  logic [10:0][7:0]   in_bytes_s;      // descriptor inputs mapped to register bytes
  logic [10:0][7:0]   sel_bytes_s;     // byte source for the next-address search
  logic [9:0]         skip_s;
  logic [3:0]         search_from_s;
  logic [3:0]         next_addr_s;
  logic [7:0]         next_data_s;
  logic               found_s;

  logic [3:0]         addr_s;
  logic [7:0]         data_s;
  logic               cs_s;
  logic               busy_s;
  logic               done_s;
  logic               error_s;
  logic               latch_s;
  logic               commit_s;
  logic               invalidate_s;

  // Map descriptor fields onto the register byte layout of the dma port
  always_comb begin
    in_bytes_s     = '0;
    in_bytes_s[0]  = src_off[7:0];
    in_bytes_s[1]  = src_off[15:8];
    in_bytes_s[2]  = {7'b000_0000, src_off[16]};
    in_bytes_s[3]  = dst_off[7:0];
    in_bytes_s[4]  = dst_off[15:8];
    in_bytes_s[5]  = {7'b000_0000, dst_off[16]};
    in_bytes_s[6]  = width;
    in_bytes_s[7]  = height[7:0];
    in_bytes_s[8]  = {7'b000_0000, height[8]};
    in_bytes_s[9]  = fill;
    in_bytes_s[10] = ctrl;
  end

  // Pick the byte source and search origin: live inputs at launch, latched bytes mid-sequence
  always_comb begin
    sel_bytes_s   = desc_r;
    search_from_s = 4'h0;
    if (state_r == ST_IDLE) begin
      sel_bytes_s   = in_bytes_s;
      search_from_s = 4'h0;
    end else begin
      sel_bytes_s   = desc_r;
      search_from_s = reg_addr + 4'h1;
    end
  end

  // Flag data registers whose byte already matches the committed shadow
  always_comb begin
    skip_s = 10'b00_0000_0000;
    for (int i = 0; i < 10; i++) begin
      skip_s[i] = SKIP_EN && shadow_valid_r && (sel_bytes_s[i] == shadow_r[i]);
    end
  end

  // First non-skipped data register at or above the search origin, else CTRL
  always_comb begin
    next_addr_s = CTRL_ADDR;
    next_data_s = sel_bytes_s[10];
    found_s     = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (!found_s && (4'(i) >= search_from_s) && !skip_s[i]) begin
        found_s     = 1'b1;
        next_addr_s = 4'(i);
        next_data_s = sel_bytes_s[i];
      end else begin
        found_s     = found_s;
      end
    end
  end

  // Next-state and next-output logic of the IDLE/WRITE sequencer
  always_comb begin
    state_s      = state_r;
    addr_s       = reg_addr;
    data_s       = reg_data;
    cs_s         = reg_cs;
    busy_s       = busy;
    done_s       = 1'b0;
    error_s      = 1'b0;
    wait_cnt_s   = wait_cnt_r;
    latch_s      = 1'b0;
    commit_s     = 1'b0;
    invalidate_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          latch_s    = 1'b1;
          state_s    = ST_WRITE;
          addr_s     = next_addr_s;
          data_s     = next_data_s;
          cs_s       = 1'b1;
          busy_s     = 1'b1;
          wait_cnt_s = '0;
        end else begin
          cs_s       = 1'b0;
          busy_s     = 1'b0;
        end
      end
      ST_WRITE: begin
        if (!reg_wait) begin
          wait_cnt_s = '0;
          if (reg_addr == CTRL_ADDR) begin
            commit_s = 1'b1;
            state_s  = ST_IDLE;
            cs_s     = 1'b0;
            busy_s   = 1'b0;
            done_s   = 1'b1;
          end else begin
            addr_s   = next_addr_s;
            data_s   = next_data_s;
          end
        end else if (TIMEOUT_EN && (wait_cnt_r == WAIT_LAST)) begin
          invalidate_s = 1'b1;
          state_s      = ST_IDLE;
          cs_s         = 1'b0;
          busy_s       = 1'b0;
          error_s      = 1'b1;
          wait_cnt_s   = '0;
        end else begin
          wait_cnt_s   = wait_cnt_r + WCW'(1);
        end
      end
      default: begin
        state_s    = ST_IDLE;
        cs_s       = 1'b0;
        busy_s     = 1'b0;
        wait_cnt_s = '0;
      end
    endcase
  end

  // Sequencer state and registered bus/status outputs
  always_ff @(posedge reg_clk or negedge reg_rst_n) begin
    if (!reg_rst_n) begin
      state_r    <= ST_IDLE;
      reg_addr   <= 4'h0;
      reg_data   <= 8'h00;
      reg_cs     <= 1'b0;
      reg_we     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      wait_cnt_r <= '0;
    end else begin
      state_r    <= state_s;
      reg_addr   <= addr_s;
      reg_data   <= data_s;
      reg_cs     <= cs_s;
      reg_we     <= cs_s;
      busy       <= busy_s;
      done       <= done_s;
      error      <= error_s;
      wait_cnt_r <= wait_cnt_s;
    end
  end

  // Descriptor capture at launch; shadow commit on CTRL accept, invalidation on abort
  always_ff @(posedge reg_clk or negedge reg_rst_n) begin
    if (!reg_rst_n) begin
      desc_r         <= '0;
      shadow_r       <= '0;
      shadow_valid_r <= 1'b0;
    end else begin
      if (latch_s) begin
        desc_r <= in_bytes_s;
      end
      if (commit_s) begin
        shadow_r       <= desc_r[9:0];
        shadow_valid_r <= 1'b1;
      end else if (invalidate_s) begin
        shadow_valid_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dma_reg_loader.sv
// Scoreboard bench for dma_reg_loader (SKIP_UNCHANGED=1, WAIT_TIMEOUT=4).
// The stimulus side works out the expected write list from the descriptor and
// the model's shadow copy, then queues it. An independent monitor pops the queue
// whenever a write is accepted or done/error pulses.
module tb_dma_reg_loader;

  localparam int WAIT_TO = 4;
  localparam logic [1:0] K_WR = 2'd0, K_DONE = 2'd1, K_ERR = 2'd2;

  typedef struct packed {
    logic [16:0] src;
    logic [16:0] dst;
    logic [7:0]  wid;
    logic [8:0]  hgt;
    logic [7:0]  fil;
    logic [7:0]  ctl;
  } desc_t;

  typedef struct packed {
    logic [1:0] kind;
    logic [3:0] addr;
    logic [7:0] data;
  } exp_t;

  typedef logic [10:0][7:0] bytes_t;

  logic        reg_clk = 1'b0;
  logic        reg_rst_n = 1'b1;
  logic        start = 1'b0;
  logic [16:0] src_off = 17'h0;
  logic [16:0] dst_off = 17'h0;
  logic [7:0]  width = 8'h0;
  logic [8:0]  height = 9'h0;
  logic [7:0]  fill = 8'h0;
  logic [7:0]  ctrl = 8'h0;
  logic        reg_wait = 1'b0;
  logic [3:0]  reg_addr;
  logic [7:0]  reg_data;
  logic        reg_cs, reg_we, busy, done, error;

  int     vectors = 0;
  int     miscompares = 0;
  exp_t   exp_q[$];
  int     plan_q[$];
  bytes_t sh_bytes = '0;
  bit     sh_valid = 1'b0;

  dma_reg_loader #(.SKIP_UNCHANGED(1), .WAIT_TIMEOUT(WAIT_TO)) dut (
    .reg_clk(reg_clk), .reg_rst_n(reg_rst_n), .start(start),
    .src_off(src_off), .dst_off(dst_off), .width(width), .height(height),
    .fill(fill), .ctrl(ctrl), .reg_addr(reg_addr), .reg_data(reg_data),
    .reg_cs(reg_cs), .reg_we(reg_we), .reg_wait(reg_wait),
    .busy(busy), .done(done), .error(error)
  );

  always #5 reg_clk = ~reg_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic see(input logic [1:0] kind, input logic [3:0] a, input logic [7:0] d);
    exp_t e;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_event: got kind %0d addr 0x%0h data 0x%02h, expected none (t=%0t)",
               kind, a, d, $time);
    end else begin
      e = exp_q.pop_front();
      chk("bus_event{kind,addr,data}", {18'd0, kind, a, d}, {18'd0, e.kind, e.addr, e.data});
    end
  endtask

  // Independent monitor: every accepted write and every status pulse consumes one expectation
  always @(negedge reg_clk) begin
    if (reg_rst_n) begin
      chk("we_equals_cs", {31'd0, reg_we}, {31'd0, reg_cs});
      chk("busy_equals_cs", {31'd0, busy}, {31'd0, reg_cs});
      if (reg_cs && reg_we && !reg_wait) see(K_WR, reg_addr, reg_data);
      if (done)  see(K_DONE, 4'h0, 8'h00);
      if (error) see(K_ERR, 4'h0, 8'h00);
    end
  end

  function automatic bytes_t to_bytes(input desc_t d);
    bytes_t b;
    b[0] = d.src[7:0];  b[1] = d.src[15:8]; b[2] = {7'd0, d.src[16]};
    b[3] = d.dst[7:0];  b[4] = d.dst[15:8]; b[5] = {7'd0, d.dst[16]};
    b[6] = d.wid;       b[7] = d.hgt[7:0];  b[8] = {7'd0, d.hgt[8]};
    b[9] = d.fil;       b[10] = d.ctl;
    return b;
  endfunction

  // Reference write plan: ascending data regs that differ from the shadow, then CTRL
  task automatic make_plan(input bytes_t b);
    plan_q.delete();
    for (int a = 0; a < 10; a++) begin
      if (!(sh_valid && (b[a] == sh_bytes[a]))) plan_q.push_back(a);
    end
    plan_q.push_back(10);
  endtask

  function automatic desc_t rand_desc();
    desc_t d;
    d.src = 17'($urandom); d.dst = 17'($urandom); d.wid = 8'($urandom);
    d.hgt = 9'($urandom);  d.fil = 8'($urandom); d.ctl = 8'($urandom);
    return d;
  endfunction

  task automatic apply_desc(input desc_t d);
    src_off = d.src; dst_off = d.dst; width = d.wid;
    height = d.hgt;  fill = d.fil;    ctrl = d.ctl;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_addr"}, {28'd0, reg_addr}, 32'd0);
    chk({tag, "_data"}, {24'd0, reg_data}, 32'd0);
    chk({tag, "_cs"},   {31'd0, reg_cs},   32'd0);
    chk({tag, "_we"},   {31'd0, reg_we},   32'd0);
    chk({tag, "_busy"}, {31'd0, busy},     32'd0);
    chk({tag, "_done"}, {31'd0, done},     32'd0);
    chk({tag, "_error"},{31'd0, error},    32'd0);
  endtask

  // One load sequence. stuck_addr: hold wait until abort. hold_addr/len: fixed stall.
  // rst_addr: assert reset while that address is presented. Use -1 to disable any of them.
  task automatic run_seq(input desc_t d, input int stuck_addr, input int hold_addr,
                         input int hold_len, input int rst_addr, input bit rnd_stall,
                         input bit mid_start);
    bytes_t b;
    int n_wr = 0, stalls = 0, stuck_cnt = 0, held = 0, consec = 0, cyc = 0;
    int stop_addr;
    bit fin = 1'b0, got_done = 1'b0, got_err = 1'b0;
    b = to_bytes(d);
    stop_addr = (stuck_addr >= 0) ? stuck_addr : rst_addr;
    make_plan(b);
    foreach (plan_q[i]) begin
      if (plan_q[i] == stop_addr) break;
      exp_q.push_back('{K_WR, 4'(plan_q[i]), b[plan_q[i]]});
      n_wr++;
    end
    if (stuck_addr >= 0) exp_q.push_back('{K_ERR, 4'h0, 8'h00});
    else if (rst_addr < 0) exp_q.push_back('{K_DONE, 4'h0, 8'h00});

    apply_desc(d);
    start = 1'b1;
    @(posedge reg_clk); #1;
    start = 1'b0;
    apply_desc(rand_desc());
    while (!fin && cyc < 300) begin
      reg_wait = 1'b0;
      if (rst_addr >= 0 && reg_cs && reg_addr == 4'(rst_addr)) begin
        reg_rst_n = 1'b0;
        #1;
        check_idle_outputs("midseq_reset");
        fin = 1'b1;
      end else begin
        start = mid_start && (cyc == 3) && busy;
        if (start) apply_desc(rand_desc());
        if (reg_cs) begin
          if (stuck_addr >= 0 && reg_addr == 4'(stuck_addr)) reg_wait = 1'b1;
          else if (hold_addr >= 0 && reg_addr == 4'(hold_addr) && held < hold_len) begin
            reg_wait = 1'b1;
            held++;
          end else if (rnd_stall && consec < 2 && $urandom_range(0, 3) == 0) reg_wait = 1'b1;
        end
        consec = reg_wait ? consec + 1 : 0;
        @(negedge reg_clk);
        cyc++;
        if (reg_cs && reg_wait) begin
          stalls++;
          if (stuck_addr >= 0 && reg_addr == 4'(stuck_addr)) stuck_cnt++;
        end
        if (done) begin
          got_done = 1'b1;
          chk("done_latency_edges", cyc - 1, n_wr + stalls);
        end
        if (error) begin
          got_err = 1'b1;
          chk("cs_low_at_error", {31'd0, reg_cs}, 32'd0);
          chk("stalls_before_abort", stuck_cnt, WAIT_TO);
        end
        fin = got_done || got_err;
        @(posedge reg_clk); #1;
      end
    end
    start = 1'b0;
    reg_wait = 1'b0;
    if (!fin) begin
      vectors++;
      miscompares++;
      $display("FAIL seq_budget: no done/error within 300 cycles, expected completion");
    end
    if (rst_addr >= 0) begin
      chk("pending_before_reset", exp_q.size(), 0);
      exp_q.delete();
      repeat (2) @(posedge reg_clk);
      #1;
      reg_rst_n = 1'b1;
      sh_valid = 1'b0;
    end else begin
      chk("scoreboard_drained", exp_q.size(), 0);
      exp_q.delete();
      if (stuck_addr >= 0) begin
        sh_valid = 1'b0;
      end else begin
        sh_bytes = b;
        sh_valid = 1'b1;
      end
    end
  endtask

  initial begin
    desc_t d1, d;
    #2 reg_rst_n = 1'b0;
    #1 check_idle_outputs("reset");
    @(posedge reg_clk); #1;
    reg_rst_n = 1'b1;
    @(posedge reg_clk); #1;

    d1 = '{17'h01010, 17'h03030, 8'h10, 9'h010, 8'h00, 8'h02};
    run_seq(d1, -1, -1, 0, -1, 1'b0, 1'b0);   // all 11 writes
    run_seq(d1, -1, -1, 0, -1, 1'b0, 1'b0);   // CTRL only
    d = d1; d.hgt = 9'h110;
    run_seq(d, -1, -1, 0, -1, 1'b0, 1'b0);    // (8,01),(A,02)
    d.wid = 8'h20;
    run_seq(d, -1, -1, 0, 6, 1'b0, 1'b0);     // reset while 0x6 is presented
    run_seq(d1, -1, 3, 3, -1, 1'b0, 1'b1);    // full reload, 3 stalls on 0x3, ignored start
    d = d1; d.dst = 17'h13030;
    run_seq(d, 5, -1, 0, -1, 1'b0, 1'b0);     // timeout on 0x5

    d = rand_desc();
    for (int n = 0; n < 40; n++) begin
      desc_t r;
      int stuck;
      r = rand_desc();
      if ($urandom_range(0, 1) == 1) d.src = r.src;
      if ($urandom_range(0, 1) == 1) d.dst = r.dst;
      if ($urandom_range(0, 1) == 1) d.wid = r.wid;
      if ($urandom_range(0, 1) == 1) d.hgt = r.hgt;
      if ($urandom_range(0, 1) == 1) d.fil = r.fil;
      if ($urandom_range(0, 1) == 1) d.ctl = r.ctl;
      stuck = -1;
      if ($urandom_range(0, 5) == 0) begin
        make_plan(to_bytes(d));
        stuck = plan_q[$urandom_range(0, plan_q.size() - 1)];
      end
      run_seq(d, stuck, -1, 0, -1, 1'b1, ($urandom_range(0, 2) == 0));
      repeat ($urandom_range(0, 2)) @(posedge reg_clk);
      #0;
    end

    repeat (3) @(posedge reg_clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, expected $finish earlier");
    $fatal(1);
  end

endmodule
